// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Runs WIDTH shift-add or restoring shift-subtract steps on magnitudes, then one sign-fix edge.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic               is_div_q;
    logic               sign_a, sign_b;
    logic               div_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // {partial product | remainder, multiplier | quotient}

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] acc_mul, acc_div, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = RUN;
            end
            RUN:  if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        neg_a = ~op[0] & a[WIDTH-1];
        neg_b = ~op[0] & b[WIDTH-1];
        abs_a = neg_a ? -a : a;
        abs_b = neg_b ? -b : b;

        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_mul = {mul_sum, acc[WIDTH-1:1]};

        // Trial subtract of divisor from the remainder shifted left by one quotient bit
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd};
        acc_div   = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

        if (!is_div_q) begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            hi_res = raw_a;
            lo_res = '1;
        end else begin
            hi_res = rem_fix;
            lo_res = quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            is_div_q <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        sign_a   <= neg_a;
                        sign_b   <= neg_b;
                        div_zero <= (b == '0);
                        raw_a    <= a;
                        opnd     <= op[1] ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt      <= '0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= is_div_q ? acc_div : acc_mul;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi   <= hi_res;
                    lo   <= lo_res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed MIPS cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // MIPS HI/LO semantics computed directly from 64-bit integer arithmetic
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        longint      sp, sq, sr;
        logic [63:0] up, v;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                v  = sp;
                eh = v[63:32]; el = v[31:0];
            end
            2'b01: begin
                up = {32'b0, x} * {32'b0, y};
                eh = up[63:32]; el = up[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    v = sq; el = v[31:0];
                    v = sr; eh = v[31:0];
                end else begin
                    el = x / y; eh = x % y;
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb, input bit with_wr);
        logic [31:0] eh, el;
        int          n;
        bit          held;
        model(o, x, y, eh, el);
        start = 1'b1; op = o; a = x; b = y;
        if (with_wr) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5; end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        n = 0; held = 1'b1;
        while (busy && n < 50) begin
            n++;
            if (hi !== ref_hi || lo !== ref_lo) held = 1'b0;
            if (disturb && n == 5) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
                op = 2'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_held"}, 64'(held), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        ref_hi = eh; ref_lo = el;
    endtask

    initial begin
        logic [31:0] x, y;
        logic [1:0]  o;
        bit          seen;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        check("mult_min_hi_const", 64'(hi), 64'h4000_0000);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        check("divu_lo_const", 64'(lo), 64'd14);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        run_op("divu_zero", 2'b11, 32'h1234, 32'd0, 1'b0, 1'b0);
        check("divu_zero_hi_const", 64'(hi), 64'h1234);
        run_op("div_zero", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi", 64'(hi), 64'hA5A5_A5A5);
        check("mtlo", 64'(lo), 64'hA5A5_A5A5);
        ref_hi = 32'hA5A5_A5A5; ref_lo = 32'hA5A5_A5A5;
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_only", 64'(hi), 64'h0BAD_F00D);
        check("mthi_only_lo", 64'(lo), 64'hA5A5_A5A5);
        ref_hi = 32'h0BAD_F00D;

        run_op("start_wr", 2'b01, 32'd3, 32'd4, 1'b0, 1'b1);
        run_op("disturb", 2'b11, 32'd1000, 32'd33, 1'b1, 1'b0);
        run_op("b2b", 2'b00, 32'hFFFF_FFF0, 32'd5, 1'b0, 1'b0);

        // Abort mid-operation with reset
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        ref_hi = '0; ref_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_hi_after", 64'(hi), 64'd0);

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            run_op("rand", o, x, y, ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit beside the main ALU in the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU on the two register-file read operands. Results go into internal HI/LO registers, which are read back for MFHI/MFLO.
- Also accepts direct HI/LO writes for MTHI/MTLO.
- Asserts busy while an operation runs; the control path stalls the PC and HI/LO readers on busy.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. An operation takes WIDTH iterations.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, launch the operation selected by op. Sampled at the rising edge.
- op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a, input, WIDTH, operand rs (multiplicand or dividend).
- b, input, WIDTH, operand rt (multiplier or divisor).
- hi_we, input, 1, MTHI strobe.
- lo_we, input, 1, MTLO strobe.
- wdata, input, WIDTH, data for MTHI/MTLO.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse when results are written.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; hi=0; lo=0; busy=0; done=0; iteration counter=0.
  - Reset has priority over everything.
  - Reset mid-operation aborts the operation and discards all partial results.
- States: IDLE, RUN, FIX.
- IDLE:
  - At an edge with start=1: latch op, |a| and |b| (absolute values for signed ops, raw values for unsigned ops) and the operand signs. Clear the accumulator and counter; go to RUN; busy=1 from the next cycle.
  - start=1 takes priority over hi_we/lo_we in the same cycle; the writes are dropped.
  - At an edge with start=0: hi_we=1 loads hi<=wdata and lo_we=1 loads lo<=wdata. Both may be written in the same edge.
- RUN: one iteration per edge; the counter increments; after WIDTH iterations go to FIX.
  - Multiply: shift-add on unsigned magnitudes giving a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract on unsigned magnitudes giving a quotient and a remainder.
- FIX (single edge):
  - Apply sign correction.
    - MULT: negate the 2*WIDTH product if the operand signs differ.
    - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - Write the result:
    - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
    - Divide: lo=quotient, hi=remainder.
  - Go to IDLE; busy=0 and done=1 in the following cycle only.
- Timing:
  - Start accepted at edge E0; busy high in the cycles after E0 through E(WIDTH+1).
  - hi/lo are updated at edge E(WIDTH+1); done is high in the cycle after E(WIDTH+1).
  - Total latency is WIDTH+1 edges (33 for WIDTH=32).
- A new start is accepted in the done cycle; done still drops after one cycle.
- start, hi_we and lo_we are ignored while busy=1. hi and lo hold their old values throughout RUN; partial results are never visible.
- Divide by zero (b=0, any divide op):
  - Runs the full latency.
  - Result is lo=all ones and hi=a as originally presented.
  - No sign correction is applied.
- Signed overflow (DIV of the most negative value by -1): lo=0x80000000, hi=0, no exception. The magnitude path handles this naturally.
- a, b and op are sampled only at the start edge; later changes have no effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234.
- Idle, hi_we=1 lo_we=1 wdata=0xA5A5A5A5 -> both registers read 0xA5A5A5A5 next cycle. Repeat with start=1 in the same cycle -> writes dropped, operation runs. hi_we pulse while busy -> hi unchanged until FIX.
- MULTU 5*6 with rst=1 at cycle 10 -> busy=0, done never pulses, hi=lo=0. Second start at cycle 5 of a running DIVU ignored; the original result is delivered. Back-to-back start in the done cycle -> second result after a further 33 cycles.
